axis_cplx_addmult_core: RTL

Parametrised two-input, two-output complex arithmetic core that sits between the payload ports of an RFNoC NoC-shell (in_a/in_b in, out0/out1 out) on the ce_clk domain.
- Joins one sample from each input stream and computes a pair of results per sample.
- Mode 0: sum and difference. Mode 1: product and conjugate product.
- Results go into independent per-output FIFOs, so each output may back-pressure separately without losing data.
- Generalises the fixed add/sub block with runtime mode, width, FIFO depth, saturation and packet-alignment checking.

---
 rtl/axis_cplx_addmult_core.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axis_cplx_addmult_core.sv
// rtl/axis_cplx_addmult_core.sv - joined two-stream complex add/sub or mult/conj-mult core with per-output FIFOs
`timescale 1ns/1ps

// Output FIFO; writes never arrive while full because the core holds a credit per entry
module axis_cplx_addmult_fifo #(
   parameter int W    = 33,
   parameter int LOG2 = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] s_tdata,
   input  logic         s_tvalid,
   output logic [W-1:0] m_tdata,
   output logic         m_tvalid,
   input  logic         m_tready
);
   localparam logic [LOG2-1:0] PTR_ONE = {{(LOG2-1){1'b0}}, 1'b1};
   localparam logic [LOG2:0]   CNT_ONE = {{LOG2{1'b0}}, 1'b1};

   logic [W-1:0]    mem [0:(1<<LOG2)-1];
   logic [LOG2-1:0] wr_ptr, rd_ptr;
   logic [LOG2:0]   count;
   logic            rd;

   assign m_tvalid = (count != '0);
   assign m_tdata  = mem[rd_ptr];
   assign rd       = m_tvalid & m_tready;

   // Storage array: plain write port, no reset needed on data
   always_ff @(posedge clk) begin
      if (s_tvalid) mem[wr_ptr] <= s_tdata;
   end

   // Pointers and occupancy; simultaneous read and write keeps count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (s_tvalid) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd)       rd_ptr <= rd_ptr + PTR_ONE;
         if (s_tvalid && !rd)      count <= count + CNT_ONE;
         else if (!s_tvalid && rd) count <= count - CNT_ONE;
      end
   end
endmodule

// Core: join, mode latch, 3-stage arithmetic pipeline, credit-based output buffering
module axis_cplx_addmult_core #(
   parameter int SAMP_W    = 16,
   parameter int FIFO_LOG2 = 4,
   parameter int ERR_CNT_W = 16
) (
   input  logic                   ce_clk,
   input  logic                   ce_rst_n,
   input  logic                   mode,
   input  logic                   clear_err,
   input  logic [2*SAMP_W-1:0]    s_a_tdata,
   input  logic                   s_a_tlast,
   input  logic                   s_a_tvalid,
   output logic                   s_a_tready,
   input  logic [2*SAMP_W-1:0]    s_b_tdata,
   input  logic                   s_b_tlast,
   input  logic                   s_b_tvalid,
   output logic                   s_b_tready,
   output logic [2*SAMP_W-1:0]    m_0_tdata,
   output logic                   m_0_tlast,
   output logic                   m_0_tvalid,
   input  logic                   m_0_tready,
   output logic [2*SAMP_W-1:0]    m_1_tdata,
   output logic                   m_1_tlast,
   output logic                   m_1_tvalid,
   input  logic                   m_1_tready,
   output logic                   tlast_err,
   output logic [ERR_CNT_W-1:0]   err_count
);
   localparam int DW = 2*SAMP_W;
   localparam int PW = 2*SAMP_W + 1;
   localparam logic [FIFO_LOG2:0]      DEPTH   = {1'b1, {FIFO_LOG2{1'b0}}};
   localparam logic [FIFO_LOG2:0]      CR_ONE  = {{FIFO_LOG2{1'b0}}, 1'b1};
   localparam logic [ERR_CNT_W-1:0]    ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
   localparam logic signed [PW-1:0]    MAXV    = {{(SAMP_W+2){1'b0}}, {(SAMP_W-1){1'b1}}};
   localparam logic signed [PW-1:0]    MINV    = {{(SAMP_W+2){1'b1}}, {(SAMP_W-1){1'b0}}};
   localparam logic signed [PW-1:0]    RND     = {{(SAMP_W+2){1'b0}}, 1'b1, {(SAMP_W-2){1'b0}}};

   logic [1:0]           rst_sync;
   logic                 rst_n_i;
   logic [FIFO_LOG2:0]   inflight0, inflight1;
   logic                 space, accept, mism, pop0, pop1;
   logic                 sof, mode_lat, mode_eff;
   logic                 s1_valid, s1_last, s1_mode;
   logic [DW-1:0]        s1_a, s1_b;
   logic                 s2_valid, s2_last, s2_mode;
   logic signed [PW-1:0] s2_p0i, s2_p0q, s2_p1i, s2_p1q;
   logic signed [PW-1:0] c_p0i, c_p0q, c_p1i, c_p1q;
   logic                 s3_valid, s3_last;
   logic [DW-1:0]        s3_m0, s3_m1;
   logic signed [DW-1:0] ar_x, ai_x, br_x, bi_x, p_rr, p_ii, p_ri, p_ir;
   logic [DW:0]          f0_out, f1_out;

   function automatic logic [SAMP_W-1:0] sat_w(input logic signed [PW-1:0] v);
      if (v > MAXV) return MAXV[SAMP_W-1:0];
      if (v < MINV) return MINV[SAMP_W-1:0];
      return v[SAMP_W-1:0];
   endfunction

   function automatic logic [SAMP_W-1:0] scale(input logic md, input logic signed [PW-1:0] v);
      logic signed [PW-1:0] t;
      t = v;
      if (md) t = (v + RND) >>> (SAMP_W-1);
      return sat_w(t);
   endfunction

   // Async assert, 2-flop synchronised release of the internal reset
   always_ff @(posedge ce_clk or negedge ce_rst_n) begin
      if (!ce_rst_n) rst_sync <= 2'b00;
      else           rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n_i = rst_sync[1];

   assign space      = rst_n_i && (inflight0 < DEPTH) && (inflight1 < DEPTH);
   assign accept     = s_a_tvalid & s_b_tvalid & space;
   assign s_a_tready = s_b_tvalid & space;
   assign s_b_tready = s_a_tvalid & space;
   assign mism       = accept & (s_a_tlast != s_b_tlast);
   assign mode_eff   = sof ? mode : mode_lat;
   assign pop0       = m_0_tvalid & m_0_tready;
   assign pop1       = m_1_tvalid & m_1_tready;

   // Credits: one per beat in pipeline or FIFO, per output channel
   always_ff @(posedge ce_clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         inflight0 <= '0;
         inflight1 <= '0;
      end else begin
         if (accept && !pop0)      inflight0 <= inflight0 + CR_ONE;
         else if (!accept && pop0) inflight0 <= inflight0 - CR_ONE;
         if (accept && !pop1)      inflight1 <= inflight1 + CR_ONE;
         else if (!accept && pop1) inflight1 <= inflight1 - CR_ONE;
      end
   end

   // Packet framing: mode is sampled only on the first beat of a packet
   always_ff @(posedge ce_clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sof      <= 1'b1;
         mode_lat <= 1'b0;
      end else if (accept) begin
         sof <= s_a_tlast;
         if (sof) mode_lat <= mode;
      end
   end

   // tlast mismatch pulse and saturating counter; clear wins but a same-cycle mismatch still counts
   always_ff @(posedge ce_clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tlast_err <= 1'b0;
         err_count <= '0;
      end else begin
         tlast_err <= mism;
         if (clear_err)                    err_count <= mism ? ERR_ONE : '0;
         else if (mism && err_count != '1) err_count <= err_count + ERR_ONE;
      end
   end

   // Stage 1: register the joined beat and the mode it belongs to
   always_ff @(posedge ce_clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_mode  <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_last <= s_a_tlast;
            s1_mode <= mode_eff;
            s1_a    <= s_a_tdata;
            s1_b    <= s_b_tdata;
         end
      end
   end

   assign ar_x = {{SAMP_W{s1_a[DW-1]}},     s1_a[DW-1:SAMP_W]};
   assign ai_x = {{SAMP_W{s1_a[SAMP_W-1]}}, s1_a[SAMP_W-1:0]};
   assign br_x = {{SAMP_W{s1_b[DW-1]}},     s1_b[DW-1:SAMP_W]};
   assign bi_x = {{SAMP_W{s1_b[SAMP_W-1]}}, s1_b[SAMP_W-1:0]};
   assign p_rr = ar_x * br_x;
   assign p_ii = ai_x * bi_x;
   assign p_ri = ar_x * bi_x;
   assign p_ir = ai_x * br_x;

   // Full-precision pre-results; both modes share one width so the pipeline depth is mode-independent
   always_comb begin
      c_p0i = '0;
      c_p0q = '0;
      c_p1i = '0;
      c_p1q = '0;
      if (s1_mode) begin
         c_p0i = {p_rr[DW-1], p_rr} - {p_ii[DW-1], p_ii};
         c_p0q = {p_ri[DW-1], p_ri} + {p_ir[DW-1], p_ir};
         c_p1i = {p_rr[DW-1], p_rr} + {p_ii[DW-1], p_ii};
         c_p1q = {p_ir[DW-1], p_ir} - {p_ri[DW-1], p_ri};
      end else begin
         c_p0i = {ar_x[DW-1], ar_x} + {br_x[DW-1], br_x};
         c_p0q = {ai_x[DW-1], ai_x} + {bi_x[DW-1], bi_x};
         c_p1i = {ar_x[DW-1], ar_x} - {br_x[DW-1], br_x};
         c_p1q = {ai_x[DW-1], ai_x} - {bi_x[DW-1], bi_x};
      end
   end

   // Stage 2: register pre-results
   always_ff @(posedge ce_clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_mode  <= 1'b0;
         s2_p0i   <= '0;
         s2_p0q   <= '0;
         s2_p1i   <= '0;
         s2_p1q   <= '0;
      end else begin
         s2_valid <= s1_valid;
         s2_last  <= s1_last;
         s2_mode  <= s1_mode;
         s2_p0i   <= c_p0i;
         s2_p0q   <= c_p0q;
         s2_p1i   <= c_p1i;
         s2_p1q   <= c_p1q;
      end
   end

   // Stage 3: round (products only) and saturate to SAMP_W
   always_ff @(posedge ce_clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s3_valid <= 1'b0;
         s3_last  <= 1'b0;
         s3_m0    <= '0;
         s3_m1    <= '0;
      end else begin
         s3_valid <= s2_valid;
         s3_last  <= s2_last;
         s3_m0    <= {scale(s2_mode, s2_p0i), scale(s2_mode, s2_p0q)};
         s3_m1    <= {scale(s2_mode, s2_p1i), scale(s2_mode, s2_p1q)};
      end
   end

   axis_cplx_addmult_fifo #(.W(DW+1), .LOG2(FIFO_LOG2)) u_fifo0 (
      .clk      (ce_clk),
      .rst_n    (rst_n_i),
      .s_tdata  ({s3_last, s3_m0}),
      .s_tvalid (s3_valid),
      .m_tdata  (f0_out),
      .m_tvalid (m_0_tvalid),
      .m_tready (m_0_tready)
   );

   axis_cplx_addmult_fifo #(.W(DW+1), .LOG2(FIFO_LOG2)) u_fifo1 (
      .clk      (ce_clk),
      .rst_n    (rst_n_i),
      .s_tdata  ({s3_last, s3_m1}),
      .s_tvalid (s3_valid),
      .m_tdata  (f1_out),
      .m_tvalid (m_1_tvalid),
      .m_tready (m_1_tready)
   );

   assign m_0_tlast = f0_out[DW];
   assign m_0_tdata = f0_out[DW-1:0];
   assign m_1_tlast = f1_out[DW];
   assign m_1_tdata = f1_out[DW-1:0];
endmodule
